// File: rtl/lsu_byte_sequencer_if.sv
// Request/response and data-memory bundle for lsu_byte_sequencer.
// slave  : the sequencer itself.
// master : its environment (MEM stage driving requests plus the data memory
//          returning read data).
interface lsu_byte_sequencer_if #(
    parameter int ADDRESS_LINE = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic                    req_size;
    logic                    req_sign;
    logic [ADDRESS_LINE-1:0] req_addr;
    logic [15:0]             req_wdata;
    logic                    resp_valid;
    logic [15:0]             resp_rdata;
    logic                    resp_err;
    logic                    stall;
    logic [ADDRESS_LINE-1:0] mem_address;
    logic [7:0]              mem_write_data;
    logic                    mem_write;
    logic                    mem_read;
    logic [7:0]              mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
        output mem_address, mem_write_data, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
        input  mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer between the MEM stage and an 8-bit data memory.
// Each byte or little-endian halfword request becomes one or two single-byte
// memory accesses; the pipeline is stalled until the one-cycle response.
// Optional build macro: MISALIGN_TRAP_EN -- odd-address halfword requests are
// answered immediately with resp_err=1 and never touch memory.
module lsu_byte_sequencer #(
    parameter int ADDRESS_LINE = 16
) (
    input logic                clock,
    input logic                reset,
    lsu_byte_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  state;
    logic                    lat_write;
    logic                    lat_size;
    logic                    lat_sign;
    logic [ADDRESS_LINE-1:0] lat_addr;
    logic [15:0]             lat_wdata;
    logic [15:0]             rdata;

    logic [ADDRESS_LINE-1:0] addr_plus_one;
    assign addr_plus_one = lat_addr + {{(ADDRESS_LINE-1){1'b0}}, 1'b1};

    // Sequencer FSM: state, latched request fields and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state              <= IDLE;
            lat_write          <= 1'b0;
            lat_size           <= 1'b0;
            lat_sign           <= 1'b0;
            lat_addr           <= '0;
            lat_wdata          <= '0;
            rdata              <= '0;
            bus.req_ready      <= 1'b1;
            bus.stall          <= 1'b0;
            bus.resp_valid     <= 1'b0;
            bus.resp_err       <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_write      <= 1'b0;
            bus.mem_read       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_write     <= bus.req_write;
                        lat_size      <= bus.req_size;
                        lat_sign      <= bus.req_sign;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        rdata         <= '0;
                        bus.req_ready <= 1'b0;
                        bus.stall     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                        if (bus.req_size && bus.req_addr[0]) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            state              <= ACC0;
                            bus.mem_address    <= bus.req_addr;
                            bus.mem_write      <= bus.req_write;
                            bus.mem_read       <= !bus.req_write;
                            bus.mem_write_data <= bus.req_write ? bus.req_wdata[7:0] : 8'h00;
                        end
`else
                        state              <= ACC0;
                        bus.mem_address    <= bus.req_addr;
                        bus.mem_write      <= bus.req_write;
                        bus.mem_read       <= !bus.req_write;
                        bus.mem_write_data <= bus.req_write ? bus.req_wdata[7:0] : 8'h00;
`endif
                    end
                end

                ACC0: begin
                    if (!lat_write) begin
                        rdata[7:0] <= bus.mem_read_data;
                    end
                    if (lat_size) begin
                        state              <= ACC1;
                        bus.mem_address    <= addr_plus_one;
                        bus.mem_write      <= lat_write;
                        bus.mem_read       <= !lat_write;
                        bus.mem_write_data <= lat_write ? lat_wdata[15:8] : 8'h00;
                    end else begin
                        state              <= RESP;
                        bus.resp_valid     <= 1'b1;
                        bus.mem_address    <= '0;
                        bus.mem_write      <= 1'b0;
                        bus.mem_read       <= 1'b0;
                        bus.mem_write_data <= '0;
                    end
                end

                ACC1: begin
                    if (!lat_write) begin
                        rdata[15:8] <= bus.mem_read_data;
                    end
                    state              <= RESP;
                    bus.resp_valid     <= 1'b1;
                    bus.mem_address    <= '0;
                    bus.mem_write      <= 1'b0;
                    bus.mem_read       <= 1'b0;
                    bus.mem_write_data <= '0;
                end

                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.stall      <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Load result formatting, only presented while the response is valid.
    always_comb begin
        bus.resp_rdata = '0;
        if (state == RESP && !lat_write) begin
            if (lat_size) begin
                bus.resp_rdata = rdata;
            end else if (lat_sign) begin
                bus.resp_rdata = {{8{rdata[7]}}, rdata[7:0]};
            end else begin
                bus.resp_rdata = {8'h00, rdata[7:0]};
            end
        end
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed self-checking bench for lsu_byte_sequencer with a 64 KiB byte
// memory model (combinational read, write on rising edge).
module tb_lsu_byte_sequencer;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [7:0]  mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_a;
    logic [7:0]  pre_d;

    lsu_byte_sequencer_if #(.ADDRESS_LINE(16)) bus ();

    lsu_byte_sequencer #(.ADDRESS_LINE(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory model plus a bench-side preload port.
    always @(posedge clock) begin
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
        if (pre_we) mem[pre_a] <= pre_d;
    end
    assign bus.mem_read_data = mem[bus.mem_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Issue one request from IDLE and check latency, data, error and strobes.
    task automatic do_req(input string tag, input logic w, input logic sz, input logic sg,
                          input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input int exp_lat,
                          input logic exp_err, input int exp_strobes);
        int   n;
        int   rd;
        int   wr;
        int   busy_bad;
        logic seen;
        logic [15:0] got_rd;
        logic got_err;
        n = 0; rd = 0; wr = 0; busy_bad = 0; seen = 1'b0;
        got_rd = 16'h0; got_err = 1'b0;
        @(negedge clock);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_sign  = sg;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        while (!seen && n < 12) begin
            @(posedge clock);
            #1;
            n++;
            bus.req_valid = 1'b0;
            if (bus.mem_read)  rd++;
            if (bus.mem_write) wr++;
            if (!bus.stall || bus.req_ready) busy_bad++;
            if (bus.resp_valid) begin
                seen    = 1'b1;
                got_rd  = bus.resp_rdata;
                got_err = bus.resp_err;
            end
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_rdata"}, {16'd0, got_rd}, {16'd0, exp_rd});
        chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        chk({tag, "_strobes"}, rd + wr, exp_strobes);
        chk({tag, "_dir"}, w ? rd : wr, 0);
        chk({tag, "_busy"}, busy_bad, 0);
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int first_resp;
        int second_resp;
        int resp_cnt;
        int busy_bad;
        logic [15:0] b2b_rd;

        total = 0;
        bad   = 0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 1'b0;
        bus.req_sign = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_strobes", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
        chk("rst_addr", {16'd0, bus.mem_address}, 32'd0);
        chk("rst_wdata", {24'd0, bus.mem_write_data}, 32'd0);
        chk("rst_rdata", {16'd0, bus.resp_rdata}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        preload(16'h0020, 8'h85);
        preload(16'h0031, 8'h3C);
        preload(16'h0032, 8'hA7);
        preload(16'h0040, 8'h00);
        preload(16'h0041, 8'h77);
        preload(16'h0050, 8'h00);
        preload(16'h0051, 8'h66);
        preload(16'hFFFF, 8'hDD);
        preload(16'h0000, 8'hEE);

        // Halfword store then load
        do_req("st_hw", 1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 3, 1'b0, 2);
        chk("mem10", {24'd0, mem[16'h0010]}, 32'hEF);
        chk("mem11", {24'd0, mem[16'h0011]}, 32'hBE);
        do_req("ld_hw", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3, 1'b0, 2);
        do_req("ld_hw_sign", 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 3, 1'b0, 2);

        // Byte loads with and without sign extension
        do_req("ld_b_s", 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'hFF85, 2, 1'b0, 1);
        do_req("ld_b_u", 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0085, 2, 1'b0, 1);
        do_req("ld_b_s_hi", 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'hFFBE, 2, 1'b0, 1);
        do_req("ld_b_s_pos", 1'b0, 1'b0, 1'b1, 16'h0031, 16'h0000, 16'h003C, 2, 1'b0, 1);

        // Byte store uses only the low data byte
        do_req("st_b", 1'b1, 1'b0, 1'b0, 16'h0050, 16'hAB12, 16'h0000, 2, 1'b0, 1);
        chk("mem50", {24'd0, mem[16'h0050]}, 32'h12);
        chk("mem51", {24'd0, mem[16'h0051]}, 32'h66);

        // Halfword store wrapping past the top of memory
        do_req("st_wrap", 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h1234, 16'h0000, 3, 1'b0, 2);
        chk("memFFFF", {24'd0, mem[16'hFFFF]}, 32'h34);
        chk("mem0000", {24'd0, mem[16'h0000]}, 32'h12);

        // Misaligned halfword load
`ifdef MISALIGN_TRAP_EN
        do_req("mis_ld", 1'b0, 1'b1, 1'b0, 16'h0031, 16'h0000, 16'h0000, 1, 1'b1, 0);
`else
        do_req("mis_ld", 1'b0, 1'b1, 1'b0, 16'h0031, 16'h0000, 16'hA73C, 3, 1'b0, 2);
`endif

        // req_valid held high across two halfword loads
        first_resp = 0; second_resp = 0; resp_cnt = 0; busy_bad = 0; b2b_rd = 16'h0;
        @(negedge clock);
        bus.req_write = 1'b0;
        bus.req_size  = 1'b1;
        bus.req_sign  = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_valid = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clock);
            #1;
            if (bus.resp_valid) begin
                resp_cnt++;
                if (first_resp == 0) first_resp = e;
                else second_resp = e;
                b2b_rd = bus.resp_rdata;
            end
            if (e != 4 && (!bus.stall || bus.req_ready)) busy_bad++;
            if (e == 4) chk("b2b_ready_after_resp", {31'd0, bus.req_ready}, 32'd1);
        end
        bus.req_valid = 1'b0;
        chk("b2b_first", first_resp, 3);
        chk("b2b_second", second_resp, 7);
        chk("b2b_count", resp_cnt, 2);
        chk("b2b_busy", busy_bad, 0);
        chk("b2b_rdata", {16'd0, b2b_rd}, 32'hBEEF);
        @(posedge clock);
        #1;
        chk("b2b_idle", {31'd0, bus.req_ready}, 32'd1);

        // Reset during ACC0 of a halfword store
        @(negedge clock);
        bus.req_write = 1'b1;
        bus.req_size  = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_wdata = 16'hAA55;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        chk("abort_in_acc0", {31'd0, bus.mem_write}, 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_strobes", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
        chk("abort_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("abort_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        busy_bad = 0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clock);
            #1;
            if (bus.resp_valid || bus.mem_write || bus.mem_read) busy_bad++;
        end
        chk("abort_quiet", busy_bad, 0);
        chk("mem40", {24'd0, mem[16'h0040]}, 32'h55);
        chk("mem41", {24'd0, mem[16'h0041]}, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
